// File: rtl/ftsd_scan_ctrl.sv
// Four-digit FTSD scan controller: per-frame snapshot of the font codes,
// one active-low digit select per slot, optional whole-display blinking.
module ftsd_scan_ctrl #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [5:0] digit0,
   input  logic [5:0] digit1,
   input  logic [5:0] digit2,
   input  logic [5:0] digit3,
   input  logic       blink_en,
   output logic [3:0] ftsd_ctl,
   output logic [5:0] ftsd_in,
   output logic       frame_done
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t         state, state_nxt;
   logic [PW-1:0]  presc, presc_nxt;
   logic [1:0]     idx, idx_nxt;
   logic [5:0]     shadow [4];
   logic [5:0]     shadow_nxt [4];
   logic [FW-1:0]  frame_cnt, frame_cnt_nxt;
   logic           blink_phase, blink_nxt;
   logic [3:0]     ctl_nxt;
   logic [5:0]     in_nxt;
   logic           fd_nxt;
   logic           wrap;

   function automatic logic [3:0] sel_decode(input logic [1:0] i);
      case (i)
         2'd0:    sel_decode = 4'b0111;
         2'd1:    sel_decode = 4'b1011;
         2'd2:    sel_decode = 4'b1101;
         2'd3:    sel_decode = 4'b1110;
         default: sel_decode = 4'b1111;
      endcase
   endfunction

   // Next-state and next-output computation; outputs are registered below.
   always_comb begin
      state_nxt     = state;
      presc_nxt     = presc;
      idx_nxt       = idx;
      shadow_nxt    = shadow;
      frame_cnt_nxt = frame_cnt;
      blink_nxt     = blink_phase;
      ctl_nxt       = 4'b1111;
      in_nxt        = 6'd0;
      fd_nxt        = 1'b0;
      wrap          = 1'b0;

      if (!en) begin
         state_nxt = ST_IDLE;
         presc_nxt = {PW{1'b0}};
         idx_nxt   = 2'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               shadow_nxt[0] = digit0;
               shadow_nxt[1] = digit1;
               shadow_nxt[2] = digit2;
               shadow_nxt[3] = digit3;
               idx_nxt       = 2'd0;
               presc_nxt     = {PW{1'b0}};
               state_nxt     = ST_RUN;
            end
            ST_RUN: begin
               if (presc == P_LAST) begin
                  presc_nxt = {PW{1'b0}};
                  idx_nxt   = idx + 2'd1;
                  if (idx == 2'd3) begin
                     wrap          = 1'b1;
                     shadow_nxt[0] = digit0;
                     shadow_nxt[1] = digit1;
                     shadow_nxt[2] = digit2;
                     shadow_nxt[3] = digit3;
                  end else begin
                     wrap = 1'b0;
                  end
               end else begin
                  presc_nxt = presc + PW'(1);
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end

      // Blink counts frame wraps only while enabled; dropping blink_en wins over a toggle.
      if (!blink_en) begin
         frame_cnt_nxt = {FW{1'b0}};
         blink_nxt     = 1'b0;
      end else if (wrap) begin
         if (frame_cnt == F_LAST) begin
            frame_cnt_nxt = {FW{1'b0}};
            blink_nxt     = ~blink_phase;
         end else begin
            frame_cnt_nxt = frame_cnt + FW'(1);
         end
      end else begin
         frame_cnt_nxt = frame_cnt;
      end

      if (en) begin
         in_nxt  = shadow_nxt[idx_nxt];
         ctl_nxt = blink_nxt ? 4'b1111 : sel_decode(idx_nxt);
         fd_nxt  = wrap;
      end else begin
         in_nxt  = 6'd0;
         ctl_nxt = 4'b1111;
         fd_nxt  = 1'b0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         presc       <= {PW{1'b0}};
         idx         <= 2'd0;
         for (int i = 0; i < 4; i++) shadow[i] <= 6'd0;
         frame_cnt   <= {FW{1'b0}};
         blink_phase <= 1'b0;
         ftsd_ctl    <= 4'b1111;
         ftsd_in     <= 6'd0;
         frame_done  <= 1'b0;
      end else begin
         state       <= state_nxt;
         presc       <= presc_nxt;
         idx         <= idx_nxt;
         for (int i = 0; i < 4; i++) shadow[i] <= shadow_nxt[i];
         frame_cnt   <= frame_cnt_nxt;
         blink_phase <= blink_nxt;
         ftsd_ctl    <= ctl_nxt;
         ftsd_in     <= in_nxt;
         frame_done  <= fd_nxt;
      end
   end

endmodule

// File: tb/tb_ftsd_scan_ctrl.sv
// Scoreboard bench for ftsd_scan_ctrl with SCAN_DIV=4, BLINK_FRAMES=2:
// stimulus queues the expected {ctl,in,frame_done} per cycle, a monitor compares.
module tb_ftsd_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst, en, blink_en;
   logic [5:0] digit0, digit1, digit2, digit3;
   logic [3:0] ftsd_ctl;
   logic [5:0] ftsd_in;
   logic       frame_done;

   logic [10:0] exp_q [$];
   string       name_q [$];
   logic [10:0] exp_v;
   string       exp_nm;
   int          total = 0;
   int          bad   = 0;

   ftsd_scan_ctrl #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .digit0     (digit0),
      .digit1     (digit1),
      .digit2     (digit2),
      .digit3     (digit3),
      .blink_en   (blink_en),
      .ftsd_ctl   (ftsd_ctl),
      .ftsd_in    (ftsd_in),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Monitor: one expected entry per cycle, checked mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_v  = exp_q.pop_front();
         exp_nm = name_q.pop_front();
         total  = total + 1;
         if ({ftsd_ctl, ftsd_in, frame_done} !== exp_v) begin
            bad = bad + 1;
            $display("FAIL %s #%0d: got ctl=%b in=%h fd=%b, want ctl=%b in=%h fd=%b",
                     exp_nm, total, ftsd_ctl, ftsd_in, frame_done,
                     exp_v[10:7], exp_v[6:1], exp_v[0]);
         end
      end
   end

   task automatic tick(input logic [3:0] c, input logic [5:0] d, input logic f, input string nm);
      @(posedge clk);
      #1;
      exp_q.push_back({c, d, f});
      name_q.push_back(nm);
   endtask

   task automatic slot(input logic [3:0] c, input logic [5:0] d, input logic f, input string nm);
      tick(c, d, f, nm);
      repeat (3) tick(c, d, 1'b0, nm);
   endtask

   task automatic frame(input logic f, input logic [5:0] a, input logic [5:0] b,
                        input logic [5:0] c, input logic [5:0] d, input logic dark,
                        input string nm);
      slot(dark ? 4'b1111 : 4'b0111, a, f,    nm);
      slot(dark ? 4'b1111 : 4'b1011, b, 1'b0, nm);
      slot(dark ? 4'b1111 : 4'b1101, c, 1'b0, nm);
      slot(dark ? 4'b1111 : 4'b1110, d, 1'b0, nm);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; blink_en = 1'b0;
      digit0 = 6'h00; digit1 = 6'h00; digit2 = 6'h00; digit3 = 6'h00;
      tick(4'b1111, 6'h00, 1'b0, "reset");
      tick(4'b1111, 6'h00, 1'b0, "reset");
      total = total + 1;
      if ({ftsd_ctl, ftsd_in, frame_done} !== {4'b1111, 6'h00, 1'b0}) begin
         bad = bad + 1;
         $display("FAIL reset_state: got ctl=%b in=%h fd=%b, want ctl=1111 in=00 fd=0",
                  ftsd_ctl, ftsd_in, frame_done);
      end

      rst = 1'b0; en = 1'b1;
      digit0 = 6'h0A; digit1 = 6'h0B; digit2 = 6'h0C; digit3 = 6'h0D;
      frame(1'b0, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 1'b0, "scan_start");
      frame(1'b1, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 1'b0, "scan_f2");

      // digit2 changes during slot 0: this frame keeps 0x0C
      tick(4'b0111, 6'h0A, 1'b1, "tear_cur");
      digit2 = 6'h15;
      repeat (3) tick(4'b0111, 6'h0A, 1'b0, "tear_cur");
      slot(4'b1011, 6'h0B, 1'b0, "tear_cur");
      slot(4'b1101, 6'h0C, 1'b0, "tear_cur");
      slot(4'b1110, 6'h0D, 1'b0, "tear_cur");

      tick(4'b0111, 6'h0A, 1'b1, "tear_next");
      blink_en = 1'b1;
      repeat (3) tick(4'b0111, 6'h0A, 1'b0, "tear_next");
      slot(4'b1011, 6'h0B, 1'b0, "tear_next");
      slot(4'b1101, 6'h15, 1'b0, "tear_next");
      slot(4'b1110, 6'h0D, 1'b0, "tear_next");

      frame(1'b1, 6'h0A, 6'h0B, 6'h15, 6'h0D, 1'b0, "blink_lit1");
      frame(1'b1, 6'h0A, 6'h0B, 6'h15, 6'h0D, 1'b1, "blink_dark1");
      frame(1'b1, 6'h0A, 6'h0B, 6'h15, 6'h0D, 1'b1, "blink_dark1");
      frame(1'b1, 6'h0A, 6'h0B, 6'h15, 6'h0D, 1'b0, "blink_lit2");
      frame(1'b1, 6'h0A, 6'h0B, 6'h15, 6'h0D, 1'b0, "blink_lit2");

      slot(4'b1111, 6'h0A, 1'b1, "blink_dark2");
      tick(4'b1111, 6'h0B, 1'b0, "blink_dark2");
      blink_en = 1'b0;
      repeat (3) tick(4'b1011, 6'h0B, 1'b0, "blink_drop");
      slot(4'b1101, 6'h15, 1'b0, "blink_drop");
      slot(4'b1110, 6'h0D, 1'b0, "blink_drop");

      slot(4'b0111, 6'h0A, 1'b1, "pre_rst");
      slot(4'b1011, 6'h0B, 1'b0, "pre_rst");
      tick(4'b1101, 6'h15, 1'b0, "pre_rst");
      rst = 1'b1;
      tick(4'b1111, 6'h00, 1'b0, "rst_mid");
      rst = 1'b0;
      slot(4'b0111, 6'h0A, 1'b0, "rst_restart");
      tick(4'b1011, 6'h0B, 1'b0, "rst_restart");
      tick(4'b1011, 6'h0B, 1'b0, "rst_restart");

      en = 1'b0;
      tick(4'b1111, 6'h00, 1'b0, "stop");
      tick(4'b1111, 6'h00, 1'b0, "stop");
      digit0 = 6'h01; digit1 = 6'h02; digit2 = 6'h03; digit3 = 6'h04;
      en = 1'b1;
      frame(1'b0, 6'h01, 6'h02, 6'h03, 6'h04, 1'b0, "fresh_start");

      // en drops on the wrap cycle: no frame_done
      en = 1'b0;
      digit0 = 6'h21; digit1 = 6'h22; digit2 = 6'h23; digit3 = 6'h24;
      tick(4'b1111, 6'h00, 1'b0, "stop_wrap");
      en = 1'b1;
      frame(1'b0, 6'h21, 6'h22, 6'h23, 6'h24, 1'b0, "restart2");
      slot(4'b0111, 6'h21, 1'b1, "restart2_wrap");

      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
         bad = bad + 1;
         $display("FAIL drain_timeout: %0d expected entries never checked", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
